// File: rtl/write_queue_pkg.sv
// Shared cache/write-path definitions: line geometry and dcache write-type codes.
package write_queue_pkg;

  localparam int unsigned LINE_WIDTH    = 128;
  localparam int unsigned OFFSET_WIDTH  = 4;
  localparam int unsigned LINE_WORD_NUM = LINE_WIDTH / 32;

  // Any code other than WR_LINE is a byte/half/word size code qualified by wstrb.
  typedef enum logic [2:0] {
    WR_BYTE = 3'b000,
    WR_HALF = 3'b001,
    WR_WORD = 3'b010,
    WR_LINE = 3'b100
  } wr_type_e;

endpackage

// File: rtl/write_queue.sv
// Small in-order write queue between the dcache and the AXI bridge data write port,
// with a line-granular read-after-write hazard check over all queued entries.
module write_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LINE_WIDTH   = write_queue_pkg::LINE_WIDTH,
  parameter int unsigned OFFSET_WIDTH = write_queue_pkg::OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_wr_req,
  input  logic [2:0]            in_wr_type,
  input  logic [31:0]           in_wr_addr,
  input  logic [3:0]            in_wr_wstrb,
  input  logic [LINE_WIDTH-1:0] in_wr_data,
  output logic                  in_wr_rdy,
  output logic                  out_wr_req,
  output logic [2:0]            out_wr_type,
  output logic [31:0]           out_wr_addr,
  output logic [3:0]            out_wr_wstrb,
  output logic [LINE_WIDTH-1:0] out_wr_data,
  input  logic                  out_wr_rdy,
  input  logic                  bridge_wr_idle,
  input  logic [31:0]           rd_chk_addr,
  output logic                  rd_hazard,
  output logic                  all_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      valid;
  logic                  push;
  logic                  pop;
  logic [DEPTH-1:0]      hit;
  logic                  unused_offset;

  logic [2:0]            type_mem  [DEPTH];
  logic [31:0]           addr_mem  [DEPTH];
  logic [3:0]            wstrb_mem [DEPTH];
  logic [LINE_WIDTH-1:0] data_mem  [DEPTH];

  // Full blocks a push even when the head is leaving in the same cycle.
  assign in_wr_rdy  = (count != CNT_W'(DEPTH));
  assign out_wr_req = (count != '0);
  assign push       = in_wr_req && in_wr_rdy;
  assign pop        = out_wr_req && out_wr_rdy;
  assign all_empty  = (count == '0) && bridge_wr_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage is deliberately left out of reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[tail]  <= in_wr_type;
      addr_mem[tail]  <= in_wr_addr;
      wstrb_mem[tail] <= in_wr_wstrb;
      data_mem[tail]  <= in_wr_data;
    end
  end

  assign out_wr_type  = type_mem[head];
  assign out_wr_addr  = addr_mem[head];
  assign out_wr_wstrb = wstrb_mem[head];
  assign out_wr_data  = data_mem[head];

  for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
    assign hit[i] = valid[i] &&
                    (addr_mem[i][31:OFFSET_WIDTH] == rd_chk_addr[31:OFFSET_WIDTH]);
  end

  assign rd_hazard     = |hit;
  assign unused_offset = ^rd_chk_addr[OFFSET_WIDTH-1:0];

endmodule

// File: tb/tb_write_queue.sv
// Scoreboard bench for write_queue: a queue-based reference model records accepted writes;
// a negedge monitor checks flags, head fields, issue order and line hazards against it.
module tb_write_queue;
  import write_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = LINE_WIDTH;

  logic          clk;
  logic          reset;
  logic          in_wr_req;
  logic [2:0]    in_wr_type;
  logic [31:0]   in_wr_addr;
  logic [3:0]    in_wr_wstrb;
  logic [LW-1:0] in_wr_data;
  logic          in_wr_rdy;
  logic          out_wr_req;
  logic [2:0]    out_wr_type;
  logic [31:0]   out_wr_addr;
  logic [3:0]    out_wr_wstrb;
  logic [LW-1:0] out_wr_data;
  logic          out_wr_rdy;
  logic          bridge_wr_idle;
  logic [31:0]   rd_chk_addr;
  logic          rd_hazard;
  logic          all_empty;

  typedef struct {
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [LW-1:0] data;
  } ent_t;

  ent_t        exp_q[$];
  bit          model_rdy = 1'b1;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [2:0]  type_pool [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  write_queue #(
    .DEPTH        (DEPTH),
    .LINE_WIDTH   (LW),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_wr_req      (in_wr_req),
    .in_wr_type     (in_wr_type),
    .in_wr_addr     (in_wr_addr),
    .in_wr_wstrb    (in_wr_wstrb),
    .in_wr_data     (in_wr_data),
    .in_wr_rdy      (in_wr_rdy),
    .out_wr_req     (out_wr_req),
    .out_wr_type    (out_wr_type),
    .out_wr_addr    (out_wr_addr),
    .out_wr_wstrb   (out_wr_wstrb),
    .out_wr_data    (out_wr_data),
    .out_wr_rdy     (out_wr_rdy),
    .bridge_wr_idle (bridge_wr_idle),
    .rd_chk_addr    (rd_chk_addr),
    .rd_hazard      (rd_hazard),
    .all_empty      (all_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit line_queued(input logic [31:0] a);
    foreach (exp_q[i])
      if (exp_q[i].addr[31:OFFSET_WIDTH] == a[31:OFFSET_WIDTH]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a write is accepted at a rising edge when the model had room.
  always @(posedge clk) begin
    if (!reset && in_wr_req && model_rdy)
      exp_q.push_back('{in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data});
  end

  // Monitor: compare outputs mid-cycle; retire the head when the bridge takes it.
  always @(negedge clk) begin
    int unsigned sz;
    if (reset) begin
      exp_q.delete();
      model_rdy = 1'b1;
      chk("rst_in_wr_rdy", in_wr_rdy, 1);
      chk("rst_out_wr_req", out_wr_req, 0);
      chk("rst_rd_hazard", rd_hazard, 0);
      chk("rst_all_empty", all_empty, bridge_wr_idle);
    end else begin
      sz = exp_q.size();
      chk("in_wr_rdy", in_wr_rdy, sz != DEPTH);
      chk("out_wr_req", out_wr_req, sz != 0);
      chk("rd_hazard", rd_hazard, line_queued(rd_chk_addr));
      chk("all_empty", all_empty, (sz == 0) && bridge_wr_idle);
      model_rdy = (sz != DEPTH);
      if (sz != 0) begin
        chk("head_type", out_wr_type, exp_q[0].typ);
        chk("head_addr", out_wr_addr, exp_q[0].addr);
        chk("head_wstrb", out_wr_wstrb, exp_q[0].wstrb);
        chk("head_data", out_wr_data, exp_q[0].data);
        if (out_wr_rdy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s);
    in_wr_type  = t;
    in_wr_addr  = a;
    in_wr_wstrb = s;
    in_wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      ok = model_rdy && !reset;
    end
    #1 in_wr_req = 1'b0;
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic push(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s);
    drive_entry(t, a, s);
    in_wr_req = 1'b1;
    wait_accept("push_timeout");
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1C00_0000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
  endfunction

  initial begin
    reset          = 1'b1;
    in_wr_req      = 1'b0;
    out_wr_rdy     = 1'b0;
    bridge_wr_idle = 1'b1;
    rd_chk_addr    = '0;
    drive_entry(3'b000, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First push: visible one cycle later, same-line read hazards
    rd_chk_addr = 32'h1C00_004C;
    push(WR_LINE, 32'h1C00_0040, 4'hF);
    @(negedge clk); #1;
    chk("first_req", out_wr_req, 1);
    chk("first_addr", out_wr_addr, 32'h1C00_0040);
    chk("first_hazard", rd_hazard, 1);

    // Fill, hold a fifth request off, then release the bridge
    do_reset();
    for (int unsigned i = 1; i <= 4; i++) push(WR_LINE, i * 32'h100, 4'hF);
    drive_entry(WR_LINE, 32'h500, 4'hF);
    in_wr_req = 1'b1;
    repeat (3) step();
    chk("full_rdy", in_wr_rdy, 0);
    out_wr_rdy = 1'b1;
    wait_accept("fifth_timeout");
    repeat (6) step();
    chk("fill_drained", out_wr_req, 0);
    out_wr_rdy = 1'b0;

    // Steady push+pop at two entries long enough to wrap the pointers
    do_reset();
    push(WR_LINE, 32'hA00, 4'hF);
    push(WR_LINE, 32'hA10, 4'hF);
    in_wr_req  = 1'b1;
    out_wr_rdy = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      drive_entry(WR_LINE, 32'hB00 + k * 32'h10, 4'hF);
      step();
      chk("steady_rdy", in_wr_rdy, 1);
      chk("steady_req", out_wr_req, 1);
    end
    in_wr_req = 1'b0;
    step();
    chk("two_left", out_wr_req, 1);
    step();
    chk("none_left", out_wr_req, 0);
    out_wr_rdy = 1'b0;

    // Sub-line write keeps its type/strobes; hazard is line-granular
    do_reset();
    push(WR_WORD, 32'h8, 4'b0011);
    @(negedge clk); #1;
    chk("word_type", out_wr_type, 3'b010);
    chk("word_wstrb", out_wr_wstrb, 4'b0011);
    rd_chk_addr = 32'h0;
    #1 chk("word_hz_same", rd_hazard, 1);
    rd_chk_addr = 32'h10;
    #1 chk("word_hz_next", rd_hazard, 0);

    // Asynchronous reset with three entries queued
    do_reset();
    push(WR_LINE, 32'hC00, 4'hF);
    push(WR_LINE, 32'hC10, 4'hF);
    push(WR_LINE, 32'hC20, 4'hF);
    rd_chk_addr = 32'hC14;
    #2 reset = 1'b1;
    #1;
    chk("arst_req", out_wr_req, 0);
    chk("arst_rdy", in_wr_rdy, 1);
    chk("arst_hz", rd_hazard, 0);
    step();
    reset      = 1'b0;
    out_wr_rdy = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      chk("no_stale", out_wr_req, 0);
    end
    out_wr_rdy = 1'b0;

    // all_empty follows bridge_wr_idle combinationally
    bridge_wr_idle = 1'b0;
    @(negedge clk); #1;
    chk("ae_busy", all_empty, 0);
    bridge_wr_idle = 1'b1;
    #1 chk("ae_idle", all_empty, 1);

    // Randomized traffic with occasional reset pulses
    for (int unsigned c = 0; c < 800; c++) begin
      step();
      reset          = ($urandom_range(0, 99) == 0);
      in_wr_req      = ($urandom_range(0, 2) != 0);
      drive_entry(type_pool[$urandom_range(0, 3)], rand_addr(), 4'($urandom()));
      out_wr_rdy     = $urandom_range(0, 1) != 0;
      bridge_wr_idle = $urandom_range(0, 1) != 0;
      rd_chk_addr    = rand_addr();
    end
    step();
    reset      = 1'b0;
    in_wr_req  = 1'b0;
    out_wr_rdy = 1'b1;
    repeat (8) step();
    chk("final_drain", out_wr_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/write_queue.md
WRITE_QUEUE -- requirements
Module: write_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write entries; power of two, 2..8.
REQ-002 Parameter LINE_WIDTH, default `LINE_WIDTH (128), bits per cache-line payload.
REQ-003 Parameter OFFSET_WIDTH, default `OFFSET_WIDTH (4), byte-offset bits within a line.
REQ-004 Single clock and asynchronous active-high reset: ports clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-high; clears queue state.
REQ-007 in_wr_req  in  1  dcache write request.
REQ-008 in_wr_type  in  3  write type; 3'b100 = full line, otherwise byte/half/word size code.
REQ-009 in_wr_addr  in  32  write address.
REQ-010 in_wr_wstrb  in  4  byte strobes for non-line writes.
REQ-011 in_wr_data  in  LINE_WIDTH  line payload; word 0 in bits [31:0].
REQ-012 in_wr_rdy  out  1  queue can accept an entry.
REQ-013 out_wr_req, out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data  out  1/3/32/4/LINE_WIDTH  head entry presented to the AXI bridge data write port.
REQ-014 out_wr_rdy  in  1  bridge data write ready.
REQ-015 bridge_wr_idle  in  1  bridge write path empty (bridge write_buffer_empty).
REQ-016 rd_chk_addr  in  32  address of a pending data/inst read to hazard-check.
REQ-017 rd_hazard  out  1  rd_chk_addr line matches a queued entry.
REQ-018 all_empty  out  1  queue empty and bridge_wr_idle high.

Function
REQ-019 Push occurs in a cycle with in_wr_req && in_wr_rdy; entry fields captured at that rising edge.
REQ-020 Pop occurs in a cycle with out_wr_req && out_wr_rdy; head advances at that edge.
REQ-021 in_wr_rdy SHALL equal (count != DEPTH); no push-through when full, even with a same-cycle pop.
REQ-022 out_wr_req SHALL equal (count != 0); out_wr_* SHALL be driven from registered head storage, stable while out_wr_req high and not popped.
REQ-023 Latency push-to-out_wr_req = 1 cycle; no combinational bypass of an empty queue.
REQ-024 Entries issue strictly in push order; each entry issues exactly once.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-026 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-027 rd_hazard combinational: 1 iff some valid entry has addr[31:OFFSET_WIDTH] == rd_chk_addr[31:OFFSET_WIDTH], regardless of entry type.
REQ-028 An entry popped in cycle N SHALL not raise rd_hazard from cycle N+1 (bridge blocks reads while its write is in flight).
REQ-029 An entry pushed in cycle N SHALL raise rd_hazard from cycle N+1.
REQ-030 all_empty = (count == 0) && bridge_wr_idle, combinational.
REQ-031 in_wr_req while full is held off; no entry is dropped or overwritten.

Reset
REQ-032 On reset assertion, asynchronously: count = 0, head = tail = 0, all entry valid bits = 0.
REQ-033 Reset values of outputs: in_wr_rdy = 1, out_wr_req = 0, rd_hazard = 0, all_empty = bridge_wr_idle.
REQ-034 Entry payload registers are not reset; reset mid-operation discards all queued entries.

Structure
REQ-035 LINE_WIDTH, OFFSET_WIDTH, LINE_WORD_NUM and the write-type encoding (line = 3'b100) come from the shared definitions header; no local redefinition.
REQ-036 Flat implementation with no sub-module; the per-entry address comparators are generated inline.

Verification
REQ-037 Reset, push line 0x1C000040 with out_wr_rdy = 0 -> out_wr_req = 1 next cycle, out_wr_addr = 0x1C000040, rd_hazard = 1 for rd_chk_addr = 0x1C00004C.
REQ-038 Push 4 lines (0x100, 0x200, 0x300, 0x400) with out_wr_rdy = 0 -> in_wr_rdy = 0; fifth request held; release out_wr_rdy -> issue order 0x100..0x400, then fifth.
REQ-039 count = 2, push and pop in the same cycle -> count stays 2; after 6 such cycles pointers wrap, order preserved, no loss.
REQ-040 Word write type 3'b010, wstrb 4'b0011, addr 0x8 -> out_wr_type = 3'b010, out_wr_wstrb = 4'b0011; rd_chk_addr 0x0 hazard = 1, 0x10 hazard = 0.
REQ-041 Assert reset with 3 entries queued -> out_wr_req = 0, in_wr_rdy = 1, rd_hazard = 0 immediately; no stale entry issues after reset.
REQ-042 Queue empty, bridge_wr_idle = 0 -> all_empty = 0; bridge_wr_idle rises -> all_empty = 1 same cycle.
